popcount30_vecgen: RTL and testbench

Weight-controlled test-vector generator for the popcount30 family; the count-to-vector inverse of a popcount. For each requested Hamming weight k it streams 30-bit vectors containing exactly k ones, rotating the ones through all bit positions. Each vector carries its exact golden count. It sits upstream of the approximate popcount cores in the characterisation harness and drives their `input_a` ports over a valid/ready handshake.

---
 rtl/popcount30_pkg.sv | 20 ++
 rtl/popcount30_therm_rot.sv | 32 +++
 rtl/popcount30_vecgen.sv | 106 ++++++++++
 tb/tb_popcount30_vecgen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount30_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popcount30_pkg
// Brief    : Shared widths, weight limit and state type for the vector generator
// Revision : 1.0
// ============================================================================
package popcount30_pkg;

    localparam int WIDTH      = 30;
    localparam int CW         = 5;
    localparam int MAX_WEIGHT = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vg_state_t;

endpackage : popcount30_pkg
`default_nettype wire

// File: rtl/popcount30_therm_rot.sv
`default_nettype none
// ============================================================================
// Module   : popcount30_therm_rot
// Brief    : Combinational rotl(therm(k), offset) over WIDTH bits
// Revision : 1.0
// ============================================================================
module popcount30_therm_rot #(
    parameter int WIDTH = popcount30_pkg::WIDTH,
    parameter int CW    = popcount30_pkg::CW
) (
    input  logic [CW-1:0]    k_i,
    input  logic [CW-1:0]    offset_i,
    output logic [WIDTH-1:0] vec_o
);
    import popcount30_pkg::*;

    logic [WIDTH-1:0]   w_therm;
    logic [2*WIDTH-1:0] w_dbl;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_therm
            assign w_therm[i] = (k_i > CW'(i));
        end
    endgenerate

    // Upper half of the doubled word shifted left is the cyclic rotation.
    assign w_dbl = {w_therm, w_therm} << offset_i;
    assign vec_o = w_dbl[2*WIDTH-1:WIDTH];

endmodule : popcount30_therm_rot
`default_nettype wire

// File: rtl/popcount30_vecgen.sv
`default_nettype none
// ============================================================================
// Module   : popcount30_vecgen
// Brief    : Streams WIDTH-bit vectors of exact Hamming weight with rotation
// Revision : 1.0
// ============================================================================
module popcount30_vecgen #(
    parameter int WIDTH = popcount30_pkg::WIDTH,
    parameter int CW    = popcount30_pkg::CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CW-1:0]    weight_i,
    input  logic [CW-1:0]    step_i,
    input  logic [15:0]      count_i,
    output logic [WIDTH-1:0] vec_o,
    output logic [CW-1:0]    weight_o,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic             busy_o,
    output logic             done_o
);
    import popcount30_pkg::*;

    vg_state_t        state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [CW-1:0]    s_q, s_d;
    logic [CW-1:0]    off_q, off_d;
    logic [15:0]      rem_q, rem_d;

    logic             w_run;
    logic             w_fire;
    logic [CW:0]      w_off_sum;
    logic [WIDTH-1:0] w_rot;

    assign w_run     = (state_q == RUN);
    assign w_fire    = w_run && vec_ready_i;
    assign w_off_sum = {1'b0, off_q} + {1'b0, s_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            off_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        off_d   = off_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    k_d     = (weight_i > CW'(MAX_WEIGHT)) ? CW'(MAX_WEIGHT) : weight_i;
                    // step_i never exceeds 2*WIDTH-1, so one subtraction reduces it.
                    s_d     = (step_i >= CW'(WIDTH)) ? (step_i - CW'(WIDTH)) : step_i;
                    off_d   = '0;
                    rem_d   = count_i;
                    state_d = (count_i == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_fire) begin
                    off_d = (w_off_sum >= (CW+1)'(WIDTH)) ?
                            CW'(w_off_sum - (CW+1)'(WIDTH)) : w_off_sum[CW-1:0];
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    popcount30_therm_rot #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_therm_rot (
        .k_i      (k_q),
        .offset_i (off_q),
        .vec_o    (w_rot)
    );

    // Outputs are gated by the state register so an async reset clears them at once.
    assign vec_valid_o = w_run;
    assign busy_o      = w_run;
    assign done_o      = (state_q == DONE);
    assign vec_o       = w_run ? w_rot : '0;
    assign weight_o    = w_run ? k_q : '0;

endmodule : popcount30_vecgen
`default_nettype wire

// File: tb/tb_popcount30_vecgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount30_vecgen
// Brief    : Self-checking bench for popcount30_vecgen against a bit-set model
// Revision : 1.0
// ============================================================================
module tb_popcount30_vecgen;

    localparam int W = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [4:0]    weight_i;
    logic [4:0]    step_i;
    logic [15:0]   count_i;
    logic [W-1:0]  vec_o;
    logic [4:0]    weight_o;
    logic          vec_valid_o;
    logic          vec_ready_i;
    logic          busy_o;
    logic          done_o;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    popcount30_vecgen #(.WIDTH(30), .CW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .weight_i    (weight_i),
        .step_i      (step_i),
        .count_i     (count_i),
        .vec_o       (vec_o),
        .weight_o    (weight_o),
        .vec_valid_o (vec_valid_o),
        .vec_ready_i (vec_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Place k ones starting at bit 'off', wrapping modulo 30.
    function automatic logic [W-1:0] model_vec(input int k, input int off);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < k; j++) v[(j + off) % W] = 1'b1;
        return v;
    endfunction

    task automatic run_burst(input int w, input int st, input int cnt,
                             input int rdy_pct, input string tag);
        int k, s, n, cyc;
        logic r;
        logic [W-1:0] ev;
        k = (w > 30) ? 30 : w;
        s = (st >= 30) ? st - 30 : st;
        @(negedge clk);
        start_i = 1'b1; weight_i = w[4:0]; step_i = st[4:0];
        count_i = cnt[15:0]; vec_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        if (cnt == 0) begin
            checks++;
            if (done_o !== 1'b1 || vec_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL %s empty_t1: done=%b valid=%b busy=%b want 1 0 0", tag, done_o, vec_valid_o, busy_o);
            end
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || vec_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s empty_t2: done=%b valid=%b want 0 0", tag, done_o, vec_valid_o);
            end
            exp_q.delete();
            return;
        end
        n = 0; cyc = 0;
        while (n < cnt && cyc < cnt * 20 + 20) begin
            ev = model_vec(k, (n * s) % 30);
            checks++;
            if (vec_valid_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 ||
                vec_o !== ev || weight_o !== k[4:0]) begin
                errors++;
                $display("FAIL %s vec%0d: valid=%b busy=%b done=%b vec=%h wt=%0d want 1 1 0 %h %0d",
                         tag, n, vec_valid_o, busy_o, done_o, vec_o, weight_o, ev, k);
            end
            if (n < exp_q.size()) begin
                checks++;
                if (vec_o !== exp_q[n]) begin
                    errors++;
                    $display("FAIL %s plan%0d: vec=%h want %h", tag, n, vec_o, exp_q[n]);
                end
            end
            r = ($urandom_range(0, 99) < rdy_pct);
            vec_ready_i = r;
            @(negedge clk);
            if (r) n++;
            cyc++;
        end
        vec_ready_i = 1'b0;
        if (n < cnt) begin
            errors++;
            $display("FAIL %s timeout: handshakes=%0d want %0d", tag, n, cnt);
        end
        checks++;
        if (done_o !== 1'b1 || vec_valid_o !== 1'b0 || busy_o !== 1'b0 || vec_o !== '0) begin
            errors++;
            $display("FAIL %s done: done=%b valid=%b busy=%b vec=%h want 1 0 0 0", tag, done_o, vec_valid_o, busy_o, vec_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b want 0", tag, done_o);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; weight_i = '0; step_i = '0;
        count_i = '0; vec_ready_i = 1'b0;
        #12;
        checks++;
        if (vec_o !== '0 || weight_o !== '0 || vec_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: vec=%h wt=%0d valid=%b busy=%b done=%b want all 0", vec_o, weight_o, vec_valid_o, busy_o, done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vec_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b done=%b want 0 0", vec_valid_o, done_o);
        end
    endtask

    task automatic test_basic();
        exp_q = '{30'h0000_0007, 30'h0000_000E, 30'h0000_001C};
        run_burst(3, 1, 3, 100, "basic");
    endtask

    task automatic test_wrap();
        exp_q = '{30'h0000_0003, 30'h2000_0001, 30'h3000_0000};
        run_burst(2, 29, 3, 100, "wrap");
    endtask

    task automatic test_clamp();
        exp_q = '{30'h3FFF_FFFF, 30'h3FFF_FFFF};
        run_burst(31, 5, 2, 100, "clamp");
    endtask

    task automatic test_empty();
        run_burst(4, 1, 0, 100, "empty");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        start_i = 1'b1; weight_i = 5'd1; step_i = 5'd1; count_i = 16'd2; vec_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (vec_o !== 30'h1 || weight_o !== 5'd1 || vec_valid_o !== 1'b1 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vec=%h wt=%0d valid=%b done=%b want 1 1 1 0", c, vec_o, weight_o, vec_valid_o, done_o);
            end
            // A start pulse in RUN with count 0 would force DONE if it were honoured.
            start_i = (c == 1);
            count_i = 16'd0;
            vec_ready_i = (c == 4);
            @(negedge clk);
        end
        start_i = 1'b0;
        checks++;
        if (vec_o !== 30'h2 || vec_valid_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_next: vec=%h valid=%b done=%b want 2 1 0", vec_o, vec_valid_o, done_o);
        end
        @(negedge clk);
        vec_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || vec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%b valid=%b want 1 0", done_o, vec_valid_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start_i = 1'b1; weight_i = 5'd5; step_i = 5'd3; count_i = 16'd4; vec_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (vec_o !== model_vec(5, 0)) begin
            errors++;
            $display("FAIL rst_v0: vec=%h want %h", vec_o, model_vec(5, 0));
        end
        @(negedge clk);
        checks++;
        if (vec_o !== model_vec(5, 3) || vec_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_v1: vec=%h valid=%b want %h 1", vec_o, vec_valid_o, model_vec(5, 3));
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (vec_valid_o !== 1'b0 || busy_o !== 1'b0 || vec_o !== '0 || weight_o !== '0) begin
            errors++;
            $display("FAIL rst_async: valid=%b busy=%b vec=%h wt=%0d want all 0", vec_valid_o, busy_o, vec_o, weight_o);
        end
        vec_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || vec_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet%0d: done=%b valid=%b want 0 0", c, done_o, vec_valid_o);
            end
        end
        exp_q = '{model_vec(5, 0), model_vec(5, 3)};
        run_burst(5, 3, 2, 100, "rst_fresh");
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            run_burst($urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(1, 10), 60, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_burst(30, 7, 4, 100, "b2b_full");
        run_burst(0, 11, 3, 100, "b2b_zero");
        run_burst(17, 31, 5, 100, "b2b_step31");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_backpressure();
        test_empty();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_popcount30_vecgen
`default_nettype wire
